// File: rtl/ht0_pkg.sv
// Shared types and constants for the hashtable0 lookup and update paths.
package ht0_pkg;

    localparam logic [31:0] HT0_MAGIC_NUM = 32'h8000_8001;
    localparam logic [11:0] HT0_EMPTY     = 12'h000;

    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_DELETE = 1'b1;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_CONFLICT  = 2'b01,
        ST_NOT_FOUND = 2'b10,
        ST_SAME      = 2'b11
    } ht0_status_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_RD   = 3'd2,
        S_CMP  = 3'd3,
        S_WR   = 3'd4,
        S_RSP  = 3'd5
    } ht0_state_e;

    typedef struct packed {
        logic        big;
        logic [10:0] seg_index;
    } ht0_entry_t;

endpackage

// File: rtl/hashtable0_hash.sv
// Combinational key -> hashtable0 index; shared bit-exactly with the lookup side.
module hashtable0_hash
    import ht0_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [31:0]       key,
    output logic [ADDR_W-1:0] idx
);

    assign idx = ADDR_W'((key & HT0_MAGIC_NUM) >> 16);

endmodule

// File: rtl/hashtable0_index_update.sv
// Insert/delete engine: read-check-write of one hashtable0 entry per request.
// Optional statistics counters are enabled with `HT0_UPD_STATS_EN.
module hashtable0_index_update
    import ht0_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 12
`ifdef HT0_UPD_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [103:0]      req_tuple,
    input  logic              req_big,
    input  logic [10:0]       req_seg_index,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef HT0_UPD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_ins,
    output logic [CNT_W-1:0]  stat_del,
    output logic [CNT_W-1:0]  stat_conf
`endif
);

    ht0_state_e        state_q, state_d;
    ht0_status_e       status_q, cmp_status;
    logic              cmp_write;
    logic              op_q;
    logic [31:0]       key_q;
    ht0_entry_t        new_q;
    logic [DATA_W-1:0] new_entry;
    logic [ADDR_W-1:0] idx;
    logic              rsp_fire;

    // Only the key fields of the tuple feed the hash.
    logic unused_tuple_bits;
    assign unused_tuple_bits = ^{req_tuple[103:48], req_tuple[31:16]};

    hashtable0_hash #(.ADDR_W(ADDR_W)) u_hash (
        .key (key_q),
        .idx (idx)
    );

    assign new_entry  = DATA_W'(new_q);
    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign mem_we     = (state_q == S_WR);
    assign rsp_valid  = (state_q == S_RSP);
    assign rsp_status = status_q;
    assign rsp_fire   = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cmp_status = ST_OK;
        cmp_write  = 1'b0;

        // An exact match is checked first: it covers both "already present" on
        // insert (including the all-zero new entry) and "found" on delete.
        if (op_q == OP_INSERT) begin
            if (mem_rdata == new_entry) begin
                cmp_status = ST_SAME;
            end else if (mem_rdata == DATA_W'(HT0_EMPTY)) begin
                cmp_status = ST_OK;
                cmp_write  = 1'b1;
            end else begin
                cmp_status = ST_CONFLICT;
            end
        end else begin
            if (mem_rdata == new_entry) begin
                cmp_status = ST_OK;
                cmp_write  = 1'b1;
            end else if (mem_rdata == DATA_W'(HT0_EMPTY)) begin
                cmp_status = ST_NOT_FOUND;
            end else begin
                cmp_status = ST_CONFLICT;
            end
        end

        case (state_q)
            S_IDLE:  if (req_valid) state_d = S_ADDR;
            S_ADDR:  state_d = S_RD;
            S_RD:    state_d = S_CMP;
            S_CMP:   state_d = cmp_write ? S_WR : S_RSP;
            S_WR:    state_d = S_RSP;
            S_RSP:   if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_INSERT;
            key_q     <= '0;
            new_q     <= '0;
            mem_addr  <= '0;
            rsp_addr  <= '0;
            mem_wdata <= '0;
            status_q  <= ST_OK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        key_q <= {req_tuple[15:0], req_tuple[47:32]};
                        new_q <= '{big: req_big, seg_index: req_seg_index};
                    end
                end
                S_ADDR: begin
                    mem_addr <= idx;
                    rsp_addr <= idx;
                end
                S_CMP: begin
                    status_q  <= cmp_status;
                    mem_wdata <= (op_q == OP_INSERT) ? new_entry : DATA_W'(HT0_EMPTY);
                end
                default: ;
            endcase
        end
    end

`ifdef HT0_UPD_STATS_EN
    // Counters advance only when the status is actually delivered, and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ins  <= '0;
            stat_del  <= '0;
            stat_conf <= '0;
        end else if (rsp_fire) begin
            if (status_q == ST_OK && op_q == OP_INSERT && stat_ins != '1)
                stat_ins <= stat_ins + CNT_W'(1);
            if (status_q == ST_OK && op_q == OP_DELETE && stat_del != '1)
                stat_del <= stat_del + CNT_W'(1);
            if (status_q == ST_CONFLICT && stat_conf != '1)
                stat_conf <= stat_conf + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hashtable0_index_update.sv
// Bench for hashtable0_index_update: vector table + scoreboard, plus RSP-stall and mid-write reset.
module tb_hashtable0_index_update;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic [103:0]  req_tuple;
    logic          req_big;
    logic [10:0]   req_seg_index;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_status;
    logic [15:0]   rsp_addr;
    logic [15:0]   mem_addr;
    logic          mem_we;
    logic [11:0]   mem_wdata;
    logic [11:0]   mem_rdata;
    logic          busy;
`ifdef HT0_UPD_STATS_EN
    logic [15:0]   stat_ins, stat_del, stat_conf;
`endif

    int checks   = 0;
    int failures = 0;

    hashtable0_index_update dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_tuple     (req_tuple),
        .req_big       (req_big),
        .req_seg_index (req_seg_index),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_status    (rsp_status),
        .rsp_addr      (rsp_addr),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .busy          (busy)
`ifdef HT0_UPD_STATS_EN
        ,
        .stat_ins      (stat_ins),
        .stat_del      (stat_del),
        .stat_conf     (stat_conf)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read table memory, one cycle read latency.
    logic [11:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic        op;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        big;
        logic [10:0] seg;
        int          hold;
        logic [1:0]  exp_status;
        logic [15:0] exp_addr;
        logic        exp_we;
        logic [11:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [1:0]  status;
        logic [15:0] addr;
        logic        we;
        logic [11:0] wdata;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    localparam logic [1:0] OK = 2'b00, CONF = 2'b01, NF = 2'b10, SAME = 2'b11;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic op, input logic [15:0] lo, input logic [15:0] hi,
                                input logic big, input logic [10:0] seg, input int hold,
                                input logic [1:0] st, input logic [15:0] addr,
                                input logic we, input logic [11:0] wdata);
        vec_t v;
        v.op = op; v.lo = lo; v.hi = hi; v.big = big; v.seg = seg; v.hold = hold;
        v.exp_status = st; v.exp_addr = addr; v.exp_we = we; v.exp_wdata = wdata;
        return v;
    endfunction

    task automatic drive_req(input logic op, input logic [15:0] lo, input logic [15:0] hi,
                             input logic big, input logic [10:0] seg);
        logic [103:0] t;
        t          = {$urandom, $urandom, $urandom, $urandom};
        t[15:0]    = lo;
        t[47:32]   = hi;
        req_valid     = 1'b1;
        req_op        = op;
        req_tuple     = t;
        req_big       = big;
        req_seg_index = seg;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e, got;
        int   lat, we_cnt, guard;
        logic [1:0]  st_now;
        logic [15:0] addr_now;

        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);

        drive_req(v.op, v.lo, v.hi, v.big, v.seg);
        @(posedge clk);
        e.status = v.exp_status; e.addr = v.exp_addr; e.we = v.exp_we; e.wdata = v.exp_wdata;
        sb_q.push_back(e);

        lat = 0; we_cnt = 0;
        while (lat < 20) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) break;
            if (mem_we) begin
                we_cnt++;
                check("wr_addr", 32'(mem_addr), 32'(sb_q[0].addr));
                check("wr_data", 32'(mem_wdata), 32'(sb_q[0].wdata));
            end
            @(posedge clk);
            lat++;
        end
        check("rsp_latency", 32'(lat), sb_q[0].we ? 32'd4 : 32'd3);
        check("write_count", 32'(we_cnt), 32'(sb_q[0].we));

        st_now = rsp_status;
        addr_now = rsp_addr;
        for (int h = 0; h < v.hold; h++) begin
            drive_req(1'b1, 16'h8001, 16'h0000, 1'b1, 11'h005);
            @(posedge clk);
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_status", 32'(rsp_status), 32'(st_now));
            check("hold_addr", 32'(rsp_addr), 32'(addr_now));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_mem_we", 32'(mem_we), 32'd0);
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        st_now = rsp_status;
        addr_now = rsp_addr;
        @(posedge clk);
        if (sb_q.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check("rsp_status", 32'(st_now), 32'(got.status));
            check("rsp_addr", 32'(addr_now), 32'(got.addr));
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n_ins, n_del, n_conf, guard;

        for (int i = 0; i < 65536; i++) ram[i] = 12'h000;
        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_tuple = '0;
        req_big = 1'b0; req_seg_index = '0; rsp_ready = 1'b0;

        vecs[0] = mk(1'b0, 16'h8001, 16'h0000, 1'b1, 11'h005, 0, OK,   16'h8000, 1'b1, 12'h805);
        vecs[1] = mk(1'b0, 16'h8001, 16'h0000, 1'b1, 11'h005, 0, SAME, 16'h8000, 1'b0, 12'h000);
        vecs[2] = mk(1'b0, 16'h8001, 16'h0000, 1'b1, 11'h006, 0, CONF, 16'h8000, 1'b0, 12'h000);
        vecs[3] = mk(1'b1, 16'h8001, 16'h0000, 1'b1, 11'h005, 0, OK,   16'h8000, 1'b1, 12'h000);
        vecs[4] = mk(1'b1, 16'h8001, 16'h0000, 1'b1, 11'h005, 0, NF,   16'h8000, 1'b0, 12'h000);
        vecs[5] = mk(1'b0, 16'h0000, 16'hABCD, 1'b0, 11'h000, 0, SAME, 16'h0000, 1'b0, 12'h000);
        vecs[6] = mk(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 11'h7FF, 0, OK,   16'h8000, 1'b1, 12'h7FF);
        vecs[7] = mk(1'b1, 16'h8000, 16'h1234, 1'b1, 11'h7FF, 0, CONF, 16'h8000, 1'b0, 12'h000);
        vecs[8] = mk(1'b1, 16'h8123, 16'h0000, 1'b0, 11'h7FF, 0, OK,   16'h8000, 1'b1, 12'h000);
        vecs[9] = mk(1'b0, 16'h0001, 16'h0000, 1'b0, 11'h007, 5, OK,   16'h0000, 1'b1, 12'h007);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_status", 32'(rsp_status), 32'd0);
        check("rst_rsp_addr", 32'(rsp_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        n_ins = 0; n_del = 0; n_conf = 0;
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
            if (vecs[i].exp_status == OK && vecs[i].op == 1'b0) n_ins++;
            if (vecs[i].exp_status == OK && vecs[i].op == 1'b1) n_del++;
            if (vecs[i].exp_status == CONF) n_conf++;
        end

`ifdef HT0_UPD_STATS_EN
        check("stat_ins", 32'(stat_ins), 32'(n_ins));
        check("stat_del", 32'(stat_del), 32'(n_del));
        check("stat_conf", 32'(stat_conf), 32'(n_conf));
`endif

        // Reset while the write pulse is active.
        @(negedge clk);
        drive_req(1'b0, 16'h8001, 16'h0000, 1'b1, 11'h003);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!mem_we && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("reach_wr", 32'(mem_we), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("wrrst_mem_we", 32'(mem_we), 32'd0);
        check("wrrst_req_ready", 32'(req_ready), 32'd1);
        check("wrrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("wrrst_busy", 32'(busy), 32'd0);
        check("wrrst_mem_addr", 32'(mem_addr), 32'd0);
        check("wrrst_mem_wdata", 32'(mem_wdata), 32'd0);
`ifdef HT0_UPD_STATS_EN
        check("wrrst_stat_ins", 32'(stat_ins), 32'd0);
`endif
        rst = 1'b0;

        // Engine recovers: delete the entry left by the stalled-response insert.
        run_vec(mk(1'b1, 16'h0001, 16'h5555, 1'b0, 11'h007, 0, OK, 16'h0000, 1'b1, 12'h000));
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
